bus_arbiter_mux: RTL and testbench

- Parametrised successor to the datapath bus multiplexer.
- Sources raise requests; the block arbitrates among them and drives a registered bus with the owner's data, a valid flag and a one-hot grant.
- A control-unit force path keeps the legacy direct-select behaviour available.
- Sits between register file / special registers / MDR / ports and every bus consumer.

---
 rtl/bus_arbiter_mux.sv | 134 +++++++++++++
 tb/tb_bus_arbiter_mux.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_mux.sv
// Registered bus multiplexer with request arbitration (round-robin or fixed priority),
// bounded lock continuation and a control-unit force path.
module bus_arbiter_mux #(
    parameter int WIDTH    = 32,
    parameter int NSRC     = 24,
    parameter int SELW     = 5,
    parameter int RR_MODE  = 1,
    parameter int LOCK_MAX = 8
) (
    input  logic                    clock,
    input  logic                    clear,
    input  logic [NSRC*WIDTH-1:0]   src_data,
    input  logic [NSRC-1:0]         req,
    input  logic                    lock,
    input  logic                    force_en,
    input  logic [SELW-1:0]         force_sel,
    output logic [WIDTH-1:0]        bus_out,
    output logic                    bus_valid,
    output logic [NSRC-1:0]         grant,
    output logic [SELW-1:0]         grant_id,
    output logic                    locked
);

    typedef enum logic [1:0] {IDLE, OWN, HOLD} state_t;

    localparam logic [SELW-1:0] RR_INIT = SELW'(NSRC - 1);
    localparam logic [SELW:0]   NSRC_W  = (SELW + 1)'(NSRC);
    localparam logic [7:0]      CNT_MAX = 8'(LOCK_MAX - 1);

    state_t            state_q, state_d;
    logic [SELW-1:0]   owner_q, owner_d;
    logic [SELW-1:0]   rr_q, rr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]  bus_q, bus_d;
    logic              locked_q, locked_d;

    logic [WIDTH-1:0]  src_arr [NSRC];
    logic [NSRC-1:0]   owner_oh;
    logic [NSRC-1:0]   others;
    logic [NSRC-1:0]   cand;
    logic              mask_prev;
    logic              win_found;
    logic [SELW-1:0]   win_idx;
    logic [SELW-1:0]   pos;

    function automatic logic [SELW-1:0] wrap_idx(input logic [SELW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NSRC) s = s - NSRC;
        return s[SELW-1:0];
    endfunction

    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
            assign src_arr[gi]  = src_data[gi*WIDTH +: WIDTH];
            assign owner_oh[gi] = (state_q != IDLE) && (owner_q == SELW'(gi));
        end
    endgenerate

    // An owner whose lock budget is spent yields once, but only to a competing requester.
    assign others    = req & ~owner_oh;
    assign mask_prev = (state_q != IDLE) && (cnt_q == CNT_MAX) && (|others);
    assign cand      = mask_prev ? others : req;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        pos       = '0;
        for (int i = 0; i < NSRC; i++) begin
            pos = (RR_MODE != 0) ? wrap_idx(rr_q, i + 1) : wrap_idx('0, i);
            if (!win_found && cand[pos]) begin
                win_found = 1'b1;
                win_idx   = pos;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_d     = rr_q;
        cnt_d    = cnt_q;
        locked_d = 1'b0;
        if (force_en) begin
            cnt_d = '0;
            if ({1'b0, force_sel} < NSRC_W) begin
                state_d = OWN;
                owner_d = force_sel;
            end else begin
                state_d = IDLE;
                owner_d = '0;
            end
        end else if (state_q != IDLE && lock && req[owner_q] && cnt_q < CNT_MAX) begin
            state_d  = HOLD;
            cnt_d    = cnt_q + 8'd1;
            locked_d = 1'b1;
        end else if (win_found) begin
            state_d = OWN;
            owner_d = win_idx;
            cnt_d   = '0;
            if (RR_MODE != 0) rr_d = win_idx;
        end else begin
            state_d = IDLE;
            owner_d = '0;
            cnt_d   = '0;
        end
        bus_d = (state_d != IDLE) ? src_arr[owner_d] : '0;
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_q     <= RR_INIT;
            cnt_q    <= '0;
            bus_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_q     <= rr_d;
            cnt_q    <= cnt_d;
            bus_q    <= bus_d;
            locked_q <= locked_d;
        end
    end

    assign bus_out   = bus_q;
    assign bus_valid = (state_q != IDLE);
    assign grant     = owner_oh;
    assign grant_id  = owner_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Bench for bus_arbiter_mux: a round-robin and a fixed-priority instance share stimulus and
// are compared every cycle against an owner/tenure reference model.
module tb_bus_arbiter_mux;

    localparam int WIDTH = 32;
    localparam int NSRC  = 24;
    localparam int SELW  = 5;
    localparam int LMAX  = 4;

    logic                  clock;
    logic                  clear;
    logic [NSRC*WIDTH-1:0] src_data;
    logic [NSRC-1:0]       req;
    logic                  lock;
    logic                  force_en;
    logic [SELW-1:0]       force_sel;

    logic [WIDTH-1:0] r_bus, f_bus;
    logic             r_valid, f_valid;
    logic [NSRC-1:0]  r_grant, f_grant;
    logic [SELW-1:0]  r_gid, f_gid;
    logic             r_locked, f_locked;

    int compared   = 0;
    int mismatched = 0;

    bus_arbiter_mux #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW), .RR_MODE(1), .LOCK_MAX(LMAX)) dut_rr (
        .clock(clock), .clear(clear), .src_data(src_data), .req(req), .lock(lock),
        .force_en(force_en), .force_sel(force_sel), .bus_out(r_bus), .bus_valid(r_valid),
        .grant(r_grant), .grant_id(r_gid), .locked(r_locked));

    bus_arbiter_mux #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW), .RR_MODE(0), .LOCK_MAX(LMAX)) dut_fp (
        .clock(clock), .clear(clear), .src_data(src_data), .req(req), .lock(lock),
        .force_en(force_en), .force_sel(force_sel), .bus_out(f_bus), .bus_valid(f_valid),
        .grant(f_grant), .grant_id(f_gid), .locked(f_locked));

    always #5 clock = ~clock;

    // owner = -1 when idle; tenure = consecutive cycles the current owner has held the bus.
    typedef struct {
        int               owner;
        int               tenure;
        int               rr;
        bit               lk;
        logic [WIDTH-1:0] bus;
    } mdl_t;

    mdl_t m_rr, m_fp;

    function automatic logic [NSRC-1:0] oh(input int i);
        logic [NSRC-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic mdl_t model_reset();
        mdl_t n;
        n.owner = -1; n.tenure = 0; n.rr = NSRC - 1; n.lk = 0; n.bus = '0;
        return n;
    endfunction

    function automatic mdl_t model_step(input mdl_t s, input bit rr_mode, input logic clr,
                                        input logic [NSRC-1:0] rq, input logic lk,
                                        input logic fe, input logic [SELW-1:0] fs,
                                        input logic [NSRC*WIDTH-1:0] sd);
        mdl_t n;
        int win;
        int c;
        logic [NSRC-1:0] pool;
        n    = s;
        n.lk = 0;
        win  = -1;
        if (!clr) begin
            n = model_reset();
        end else if (fe && int'(fs) < NSRC) begin
            n.owner = int'(fs); n.tenure = 1;
        end else if (fe) begin
            n.owner = -1; n.tenure = 0;
        end else if (s.owner >= 0 && lk && rq[s.owner] && s.tenure < LMAX) begin
            n.tenure = s.tenure + 1; n.lk = 1;
        end else begin
            pool = rq;
            if (s.owner >= 0 && s.tenure >= LMAX && (rq & ~oh(s.owner)) != '0)
                pool[s.owner] = 1'b0;
            for (int k = 1; k <= NSRC; k++) begin
                c = rr_mode ? (s.rr + k) % NSRC : k - 1;
                if (win < 0 && pool[c]) win = c;
            end
            if (win >= 0) begin
                n.owner = win; n.tenure = 1;
                if (rr_mode) n.rr = win;
            end else begin
                n.owner = -1; n.tenure = 0;
            end
        end
        n.bus = (n.owner >= 0) ? sd[n.owner*WIDTH +: WIDTH] : '0;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " rr bus"},    r_bus,    m_rr.bus);
        chk({tag, " rr valid"},  r_valid,  m_rr.owner >= 0);
        chk({tag, " rr grant"},  r_grant,  (m_rr.owner >= 0) ? oh(m_rr.owner) : '0);
        chk({tag, " rr gid"},    r_gid,    (m_rr.owner >= 0) ? m_rr.owner : 0);
        chk({tag, " rr locked"}, r_locked, m_rr.lk);
        chk({tag, " fp bus"},    f_bus,    m_fp.bus);
        chk({tag, " fp valid"},  f_valid,  m_fp.owner >= 0);
        chk({tag, " fp grant"},  f_grant,  (m_fp.owner >= 0) ? oh(m_fp.owner) : '0);
        chk({tag, " fp gid"},    f_gid,    (m_fp.owner >= 0) ? m_fp.owner : 0);
        chk({tag, " fp locked"}, f_locked, m_fp.lk);
    endtask

    task automatic rand_src();
        for (int i = 0; i < NSRC; i++) src_data[i*WIDTH +: WIDTH] = $urandom;
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        m_rr = model_step(m_rr, 1'b1, clear, req, lock, force_en, force_sel, src_data);
        m_fp = model_step(m_fp, 1'b0, clear, req, lock, force_en, force_sel, src_data);
        #1;
        check_model(tag);
        $display("step %-8s req=%06h lock=%0b force=%0b/%0d | rr gid=%0d lk=%0b | fp gid=%0d lk=%0b",
                 tag, req, lock, force_en, force_sel, r_gid, r_locked, f_gid, f_locked);
        rand_src();
    endtask

    int seq_rr [5] = '{3, 7, 20, 3, 7};
    logic [NSRC*WIDTH-1:0] sd;

    initial begin
        clock = 0; clear = 0; req = '1; lock = 0; force_en = 0; force_sel = '0;
        rand_src();
        m_rr = model_reset();
        m_fp = model_reset();

        step("reset0");
        step("reset1");
        chk("reset valid", r_valid, 0);
        chk("reset grant", r_grant, 0);
        chk("reset bus",   r_bus,   0);

        clear = 1;
        step("release");
        chk("release rr gid", r_gid, 0);
        chk("release fp gid", f_gid, 0);

        req = oh(3) | oh(7) | oh(20);
        for (int i = 0; i < 5; i++) begin
            sd = src_data;
            step("rrseq");
            chk("rrseq rr gid", r_gid, seq_rr[i]);
            chk("rrseq rr bus", r_bus, sd[seq_rr[i]*WIDTH +: WIDTH]);
            chk("rrseq fp gid", f_gid, 3);
        end
        req = oh(7) | oh(20);
        step("drop3");
        chk("drop3 fp gid", f_gid, 7);

        req = oh(5) | oh(9); lock = 1; force_en = 1; force_sel = 5;
        step("lockfrc");
        chk("lock start gid", r_gid, 5);
        chk("lock start locked", r_locked, 0);
        force_en = 0;
        for (int i = 0; i < 3; i++) begin
            step("hold");
            chk("hold rr gid", r_gid, 5);
            chk("hold rr locked", r_locked, 1);
            chk("hold fp locked", f_locked, 1);
        end
        step("expire");
        chk("expire rr gid", r_gid, 9);
        chk("expire fp gid", f_gid, 9);
        chk("expire locked", r_locked, 0);
        req = oh(5);
        for (int i = 0; i < 8; i++) begin
            step("sole");
            if (i > 0) chk("sole rr gid", r_gid, 5);
            if (i > 0) chk("sole fp gid", f_gid, 5);
        end

        lock = 0; req = oh(20);
        step("ptr20");
        chk("ptr20 rr gid", r_gid, 20);
        req = '0; force_en = 1; force_sel = 21;
        sd = src_data;
        step("force21");
        chk("force21 gid", r_gid, 21);
        chk("force21 bus", r_bus, sd[21*WIDTH +: WIDTH]);
        force_sel = 30;
        step("force30");
        chk("force30 valid", r_valid, 0);
        chk("force30 bus", r_bus, 0);
        force_en = 0; req = oh(3) | oh(7);
        step("ptrkeep");
        chk("ptrkeep rr gid", r_gid, 3);

        force_en = 1; force_sel = 5; req = oh(5); lock = 1;
        step("mh_frc");
        force_en = 0;
        step("mh_hold");
        chk("midhold locked", r_locked, 1);
        clear = 0;
        step("mh_rst");
        chk("midhold rst valid", r_valid, 0);
        chk("midhold rst grant", r_grant, 0);
        chk("midhold rst bus", r_bus, 0);
        chk("midhold rst locked", r_locked, 0);
        clear = 1; lock = 0; req = oh(5) | oh(6);
        step("mh_rel");
        chk("midhold rel rr gid", r_gid, 5);
        chk("midhold rel fp gid", f_gid, 5);

        for (int n = 0; n < 400; n++) begin
            clear = ($urandom_range(0, 49) != 0);
            if ($urandom_range(0, 2) == 0) req = NSRC'($urandom & $urandom);
            lock      = ($urandom_range(0, 3) != 0);
            force_en  = ($urandom_range(0, 15) == 0);
            force_sel = SELW'($urandom_range(0, 31));
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
